// File: rtl/brew_pkg.sv
// Shared encodings and default dwell durations for the brew unit arbiter.
package brew_pkg;

   localparam int CNT_W = 4;

   localparam int DEF_CUP_CYC  = 2;
   localparam int DEF_ES_CYC   = 4;
   localparam int DEF_ESL_CYC  = 8;
   localparam int DEF_MILK_CYC = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b000,
      ST_CUP  = 3'b001,
      ST_POUR = 3'b010,
      ST_MILK = 3'b011,
      ST_DONE = 3'b100
   } state_t;

   typedef enum logic [1:0] {
      DRINK_NONE = 2'b00,
      DRINK_CAPP = 2'b01,
      DRINK_ESP  = 2'b10,
      DRINK_LONG = 2'b11
   } drink_t;

   // A dwell must fit the counter: 1..16 cycles, loaded as duration-1.
   function automatic logic dur_ok(input int d);
      return (d >= 1) && (d <= (1 << CNT_W));
   endfunction

   function automatic logic [CNT_W-1:0] dur_load(input int d);
      return CNT_W'(d - 1);
   endfunction

endpackage

// File: rtl/brew_arbiter_if.sv
// Panel-side request/grant signals and actuator/status outputs of the brew unit.
interface brew_arbiter_if;
   import brew_pkg::*;

   logic       req0;
   logic [1:0] drink0;
   logic       req1;
   logic [1:0] drink1;
   logic       grant0;
   logic       grant1;
   logic       done0;
   logic       done1;
   logic       cup;
   logic       pour;
   logic       milk;
   logic       busy;
   logic [2:0] state_reg;

   modport master (
      output req0, drink0, req1, drink1,
      input  grant0, grant1, done0, done1, cup, pour, milk, busy, state_reg
   );

   modport slave (
      input  req0, drink0, req1, drink1,
      output grant0, grant1, done0, done1, cup, pour, milk, busy, state_reg
   );

endinterface

// File: rtl/brew_timer.sv
// Dwell down-counter: loads on state entry, counts to zero and holds there.
module brew_timer
   import brew_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/brew_arbiter.sv
// Two-panel round-robin arbiter and brew sequencer (cup, pour, optional milk, done).
module brew_arbiter
   import brew_pkg::*;
#(
   parameter int CUP_CYC  = DEF_CUP_CYC,
   parameter int ES_CYC   = DEF_ES_CYC,
   parameter int ESL_CYC  = DEF_ESL_CYC,
   parameter int MILK_CYC = DEF_MILK_CYC
)
(
   input  logic         clock,
   input  logic         reset,
   brew_arbiter_if.slave bus
);

   if (!dur_ok(CUP_CYC) || !dur_ok(ES_CYC) || !dur_ok(ESL_CYC) || !dur_ok(MILK_CYC)) begin : g_bad_duration
      $error("brew_arbiter: every duration parameter must lie in 1..16");
   end

   localparam logic [CNT_W-1:0] CUP_LD  = dur_load(CUP_CYC);
   localparam logic [CNT_W-1:0] ES_LD   = dur_load(ES_CYC);
   localparam logic [CNT_W-1:0] ESL_LD  = dur_load(ESL_CYC);
   localparam logic [CNT_W-1:0] MILK_LD = dur_load(MILK_CYC);

   state_t           state_q;
   state_t           state_d;
   drink_t           drink_q;
   logic             winner_q;
   logic             last_q;
   logic             valid0;
   logic             valid1;
   logic             pick1;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic [CNT_W-1:0] count;
   logic             cnt_zero;

   assign valid0 = bus.req0 && (bus.drink0 != 2'b00);
   assign valid1 = bus.req1 && (bus.drink1 != 2'b00);
   // Panel 1 wins alone, or on a tie when panel 0 was served last.
   assign pick1  = valid1 && (!valid0 || !last_q);

   brew_timer u_timer (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .value (load_val),
      .count (count),
      .zero  (cnt_zero)
   );

   // State register plus the order latched at acceptance time.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         drink_q  <= DRINK_NONE;
         winner_q <= 1'b0;
         last_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && (valid0 || valid1)) begin
            drink_q  <= drink_t'(pick1 ? bus.drink1 : bus.drink0);
            winner_q <= pick1;
            last_q   <= pick1;
         end
      end
   end

   // Next state, and the dwell count to load whenever the state changes.
   always_comb begin
      state_d  = state_q;
      load_val = '0;
      case (state_q)
         ST_IDLE: if (valid0 || valid1) state_d = ST_CUP;
         ST_CUP:  if (cnt_zero) state_d = ST_POUR;
         ST_POUR: if (cnt_zero) state_d = (drink_q == DRINK_CAPP) ? ST_MILK : ST_DONE;
         ST_MILK: if (cnt_zero) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      case (state_d)
         ST_CUP:  load_val = CUP_LD;
         ST_POUR: load_val = (drink_q == DRINK_LONG) ? ESL_LD : ES_LD;
         ST_MILK: load_val = MILK_LD;
         default: load_val = '0;
      endcase
   end

   assign load = (state_d != state_q);

   // Moore outputs; the grant is the CUP cycle whose count is still freshly loaded.
   always_comb begin
      bus.grant0    = 1'b0;
      bus.grant1    = 1'b0;
      bus.done0     = 1'b0;
      bus.done1     = 1'b0;
      bus.cup       = (state_q == ST_CUP);
      bus.pour      = (state_q == ST_POUR);
      bus.milk      = (state_q == ST_MILK);
      bus.busy      = (state_q != ST_IDLE);
      bus.state_reg = state_q;
      if (state_q == ST_CUP && count == CUP_LD) begin
         bus.grant0 = !winner_q;
         bus.grant1 = winner_q;
      end
      if (state_q == ST_DONE) begin
         bus.done0 = !winner_q;
         bus.done1 = winner_q;
      end
   end

endmodule
